// File: rtl/bias_array_pkg.sv
// Shared definitions for the multi-lane bias adder.
//
// Holds the default geometry, a safe clog2 (never returns less than 1, so
// one-entry index ports still get a legal width), and the signed saturation
// bounds derived from a data width.
package bias_array_pkg;

    localparam int DEFAULT_LANES  = 4;
    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_SETS   = 4;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Largest and smallest representable signed value for a given width.
    function automatic longint sat_max_val(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint sat_min_val(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_SAT_MAX = DEFAULT_DATA_W'(sat_max_val(DEFAULT_DATA_W));
    localparam logic [DEFAULT_DATA_W-1:0] DEFAULT_SAT_MIN = DEFAULT_DATA_W'(sat_min_val(DEFAULT_DATA_W));

endpackage

// File: rtl/bias_array_lane.sv
// bias_lane: one column of the bias array.
//
// Adds a signed bias to a signed data word, clamps or wraps the result, and
// registers it together with the valid flag (1-cycle latency, no hold: an
// invalid beat drives zero data and zero valid).
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   valid         input beat valid
//   data, bias    signed operands, DATA_W bits
//   z_data        registered result
//   z_valid       registered valid
//   ovf           combinational pulse: this beat is valid and overflows
module bias_lane
    import bias_array_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] z_data,
    output logic              z_valid,
    output logic              ovf
);

    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'(sat_max_val(DATA_W));
    localparam logic [DATA_W-1:0] SAT_MIN = DATA_W'(sat_min_val(DATA_W));

    logic [DATA_W:0]   sum;
    logic              overflow;
    logic [DATA_W-1:0] result;

    // One extra bit of headroom: the sum overflows exactly when the two top
    // bits of the extended sum disagree; the top bit then gives the true sign.
    always_comb begin
        sum      = {data[DATA_W-1], data} + {bias[DATA_W-1], bias};
        overflow = sum[DATA_W] ^ sum[DATA_W-1];
        result   = sum[DATA_W-1:0];
        if (SATURATE && overflow) begin
            result = sum[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end

    assign ovf = valid & overflow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_data  <= '0;
            z_valid <= 1'b0;
        end else begin
            z_valid <= valid;
            z_data  <= valid ? result : '0;
        end
    end

endmodule

// File: rtl/bias_array.sv
// bias_array: LANES parallel bias adders between the systolic array and the
// activation stage.
//
// Owns a SETS x LANES bias register file (write port below) and per-lane
// sticky overflow flags. Each beat selects one bias set for all lanes.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   bias_sys_data_in    lane i at [i*DATA_W +: DATA_W], signed
//   bias_sys_valid_in   per-lane valid
//   bias_set_sel        bias set for this beat (out of range reads bias 0)
//   bias_wr_en/_set/_lane/_data   bias write port (out of range ignored)
//   bias_sat_clr        clears all sticky flags (a same-edge overflow wins)
//   bias_z_data_out     registered results
//   bias_z_valid_out    registered per-lane valid
//   bias_sat_flag       sticky per-lane overflow flags
module bias_array
    import bias_array_pkg::*;
#(
    parameter int LANES    = DEFAULT_LANES,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SETS     = DEFAULT_SETS,
    parameter bit SATURATE = 1'b1,
    localparam int SET_W   = safe_clog2(SETS),
    localparam int LANE_W  = safe_clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES*DATA_W-1:0] bias_sys_data_in,
    input  logic [LANES-1:0]        bias_sys_valid_in,
    input  logic [SET_W-1:0]        bias_set_sel,
    input  logic                    bias_wr_en,
    input  logic [SET_W-1:0]        bias_wr_set,
    input  logic [LANE_W-1:0]       bias_wr_lane,
    input  logic [DATA_W-1:0]       bias_wr_data,
    input  logic                    bias_sat_clr,
    output logic [LANES*DATA_W-1:0] bias_z_data_out,
    output logic [LANES-1:0]        bias_z_valid_out,
    output logic [LANES-1:0]        bias_sat_flag
);

    logic [SETS-1:0][LANES-1:0][DATA_W-1:0] bias_mem;
    logic [LANES-1:0][DATA_W-1:0]           bias_rd;
    logic [LANES-1:0]                       lane_ovf;

    // Decoded write: an index that matches no entry simply writes nothing,
    // which is how out-of-range sets/lanes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_mem <= '0;
        end else if (bias_wr_en) begin
            for (int s = 0; s < SETS; s++) begin
                for (int l = 0; l < LANES; l++) begin
                    if (bias_wr_set == SET_W'(s) && bias_wr_lane == LANE_W'(l)) begin
                        bias_mem[s][l] <= bias_wr_data;
                    end
                end
            end
        end
    end

    // Decoded read: reads the pre-edge contents, so a same-cycle write to
    // the selected entry is only seen on the following beat. A select that
    // matches no set leaves the bias at zero.
    always_comb begin
        bias_rd = '0;
        for (int s = 0; s < SETS; s++) begin
            if (bias_set_sel == SET_W'(s)) begin
                bias_rd = bias_mem[s];
            end
        end
    end

    // Sticky flags: a new overflow takes priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_sat_flag <= '0;
        end else begin
            bias_sat_flag <= lane_ovf | (bias_sat_flag & ~{LANES{bias_sat_clr}});
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bias_lane #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .valid   (bias_sys_valid_in[i]),
            .data    (bias_sys_data_in[i*DATA_W +: DATA_W]),
            .bias    (bias_rd[i]),
            .z_data  (bias_z_data_out[i*DATA_W +: DATA_W]),
            .z_valid (bias_z_valid_out[i]),
            .ovf     (lane_ovf[i])
        );
    end

endmodule

// File: tb/tb_bias_array.sv
// Self-checking bench for bias_array. Two instances: a default saturating
// build (a_*) and a wrapping build with SETS=5 / SET_W=3 (w_*), each tracked
// by an arithmetic reference model of the bias table, outputs and flags.
module tb_bias_array;

    localparam int LANES   = 4;
    localparam int DATA_W  = 16;
    localparam int SETS    = 4;
    localparam int SET_W   = 2;
    localparam int LANE_W  = 2;
    localparam int W_SETS  = 5;
    localparam int W_SET_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [LANES*DATA_W-1:0] data_in = '0;
    logic [LANES-1:0]        valid_in = '0;
    logic [SET_W-1:0]        set_sel = '0;
    logic                    wr_en = 1'b0;
    logic [SET_W-1:0]        wr_set = '0;
    logic [LANE_W-1:0]       wr_lane = '0;
    logic [DATA_W-1:0]       wr_data = '0;
    logic                    sat_clr = 1'b0;
    logic [LANES*DATA_W-1:0] a_z_data;
    logic [LANES-1:0]        a_z_valid, a_flag;

    logic [LANES*DATA_W-1:0] w_data_in = '0;
    logic [LANES-1:0]        w_valid_in = '0;
    logic [W_SET_W-1:0]      w_set_sel = '0;
    logic                    w_wr_en = 1'b0;
    logic [W_SET_W-1:0]      w_wr_set = '0;
    logic [LANE_W-1:0]       w_wr_lane = '0;
    logic [DATA_W-1:0]       w_wr_data = '0;
    logic                    w_sat_clr = 1'b0;
    logic [LANES*DATA_W-1:0] w_z_data;
    logic [LANES-1:0]        w_z_valid, w_flag;

    bias_array dut_a (
        .clk(clk), .rst(rst),
        .bias_sys_data_in(data_in), .bias_sys_valid_in(valid_in), .bias_set_sel(set_sel),
        .bias_wr_en(wr_en), .bias_wr_set(wr_set), .bias_wr_lane(wr_lane), .bias_wr_data(wr_data),
        .bias_sat_clr(sat_clr),
        .bias_z_data_out(a_z_data), .bias_z_valid_out(a_z_valid), .bias_sat_flag(a_flag)
    );

    bias_array #(.SETS(W_SETS), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst),
        .bias_sys_data_in(w_data_in), .bias_sys_valid_in(w_valid_in), .bias_set_sel(w_set_sel),
        .bias_wr_en(w_wr_en), .bias_wr_set(w_wr_set), .bias_wr_lane(w_wr_lane), .bias_wr_data(w_wr_data),
        .bias_sat_clr(w_sat_clr),
        .bias_z_data_out(w_z_data), .bias_z_valid_out(w_z_valid), .bias_sat_flag(w_flag)
    );

    // Reference model state
    logic [DATA_W-1:0]       bias_a [SETS][LANES];
    logic [DATA_W-1:0]       bias_w [W_SETS][LANES];
    logic [LANES*DATA_W-1:0] exp_a_data, exp_w_data;
    logic [LANES-1:0]        exp_a_valid, exp_w_valid, exp_a_flag, exp_w_flag;

    int tests_run = 0;
    int tests_failed = 0;

    function automatic logic [DATA_W-1:0] add_model(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] b,
                                                    input bit sat, output bit ovf);
        int s;
        s   = int'($signed(d)) + int'($signed(b));
        ovf = (s > 32767) || (s < -32768);
        if (ovf && sat) s = (s > 0) ? 32767 : -32768;
        return DATA_W'(s);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) for (int l = 0; l < LANES; l++) bias_a[s][l] = '0;
        for (int s = 0; s < W_SETS; s++) for (int l = 0; l < LANES; l++) bias_w[s][l] = '0;
        exp_a_data = '0; exp_a_valid = '0; exp_a_flag = '0;
        exp_w_data = '0; exp_w_valid = '0; exp_w_flag = '0;
    endtask

    // Advance one clock: model the edge using the inputs in place before it,
    // then leave the bench 1 time unit after the edge for sampling.
    task automatic tick();
        logic [LANES*DATA_W-1:0] na, nw;
        logic [LANES-1:0] fa, fw;
        logic [DATA_W-1:0] b;
        bit ov;
        bit live;
        live = rst;
        na = '0; nw = '0;
        fa = exp_a_flag & ~{LANES{sat_clr}};
        fw = exp_w_flag & ~{LANES{w_sat_clr}};
        for (int i = 0; i < LANES; i++) begin
            b = (int'(set_sel) < SETS) ? bias_a[set_sel][i] : '0;
            if (valid_in[i]) begin
                na[i*DATA_W +: DATA_W] = add_model(data_in[i*DATA_W +: DATA_W], b, 1'b1, ov);
                if (ov) fa[i] = 1'b1;
            end
            b = (int'(w_set_sel) < W_SETS) ? bias_w[w_set_sel][i] : '0;
            if (w_valid_in[i]) begin
                nw[i*DATA_W +: DATA_W] = add_model(w_data_in[i*DATA_W +: DATA_W], b, 1'b0, ov);
                if (ov) fw[i] = 1'b1;
            end
        end
        @(posedge clk);
        if (!live) begin
            model_reset();
        end else begin
            exp_a_data = na; exp_a_valid = valid_in; exp_a_flag = fa;
            exp_w_data = nw; exp_w_valid = w_valid_in; exp_w_flag = fw;
            if (wr_en && int'(wr_set) < SETS) bias_a[wr_set][wr_lane] = wr_data;
            if (w_wr_en && int'(w_wr_set) < W_SETS) bias_w[w_wr_set][w_wr_lane] = w_wr_data;
        end
        #1;
    endtask

    task automatic write_a(input int s, input int l, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_set = SET_W'(s); wr_lane = LANE_W'(l); wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic write_w(input int s, input int l, input logic [DATA_W-1:0] d);
        w_wr_en = 1'b1; w_wr_set = W_SET_W'(s); w_wr_lane = LANE_W'(l); w_wr_data = d;
        tick();
        w_wr_en = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        data_in = {4{16'h5A5A}}; valid_in = '1; set_sel = 1; sat_clr = 1'b0;
        wr_en = 1'b1; wr_set = 1; wr_lane = 0; wr_data = 16'h1111;
        w_data_in = {4{16'h7F00}}; w_valid_in = '1; w_wr_en = 1'b1; w_wr_data = 16'h7F00;
        tick(); tick();
        tests_run++; if (a_z_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_a_data: got %h want 0", a_z_data); end
        tests_run++; if (a_z_valid !== '0) begin tests_failed++; $display("[TB] FAIL reset_a_valid: got %b want 0", a_z_valid); end
        tests_run++; if (a_flag !== '0) begin tests_failed++; $display("[TB] FAIL reset_a_flag: got %b want 0", a_flag); end
        tests_run++; if (w_z_data !== '0 || w_z_valid !== '0 || w_flag !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_w_outputs: got %h/%b/%b want 0", w_z_data, w_z_valid, w_flag);
        end
        rst = 1'b1;
        data_in = '0; valid_in = '0; wr_en = 1'b0;
        w_data_in = '0; w_valid_in = '0; w_wr_en = 1'b0;
        tick();
        tests_run++; if (a_z_valid !== '0 || a_z_data !== '0) begin
            tests_failed++; $display("[TB] FAIL reset_release_idle: got %h/%b want 0", a_z_data, a_z_valid);
        end
    endtask

    task automatic test_load();
        write_a(1, 0, 16'h0100);
        write_a(1, 1, 16'hFF00);
        write_a(1, 2, 16'h0000);
        write_a(1, 3, 16'h0080);
        data_in = {4{16'h0200}}; valid_in = 4'hF; set_sel = 1;
        tick();
        tests_run++; if (a_z_data !== {16'h0280, 16'h0200, 16'h0100, 16'h0300}) begin
            tests_failed++; $display("[TB] FAIL load_data: got %h want 0280020001000300", a_z_data);
        end
        tests_run++; if (a_z_valid !== 4'hF) begin tests_failed++; $display("[TB] FAIL load_valid: got %b want 1111", a_z_valid); end
    endtask

    task automatic test_lane_valid();
        valid_in = 4'b0101;
        tick();
        tests_run++; if (a_z_data !== {16'h0000, 16'h0200, 16'h0000, 16'h0300}) begin
            tests_failed++; $display("[TB] FAIL lane_valid_data: got %h want 0000020000000300", a_z_data);
        end
        tests_run++; if (a_z_valid !== 4'b0101) begin tests_failed++; $display("[TB] FAIL lane_valid_valid: got %b want 0101", a_z_valid); end
        valid_in = '0;
        tick();
        tests_run++; if (a_z_data !== '0 || a_z_valid !== '0) begin
            tests_failed++; $display("[TB] FAIL lane_valid_drop: got %h/%b want 0", a_z_data, a_z_valid);
        end
    endtask

    task automatic test_saturation();
        write_a(0, 0, 16'h7000);
        write_a(0, 1, 16'h9000);
        data_in = {16'h0000, 16'h0000, 16'h9000, 16'h7000}; set_sel = 0; valid_in = 4'b0011;
        tick();
        tests_run++; if (a_z_data !== {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}) begin
            tests_failed++; $display("[TB] FAIL sat_clamp: got %h want 0000000080007fff", a_z_data);
        end
        tests_run++; if (a_flag !== 4'b0011) begin tests_failed++; $display("[TB] FAIL sat_flag_set: got %b want 0011", a_flag); end
        valid_in = '0;
        tick();
        tests_run++; if (a_flag !== 4'b0011) begin tests_failed++; $display("[TB] FAIL sat_flag_sticky: got %b want 0011", a_flag); end
        sat_clr = 1'b1; valid_in = 4'b0001;
        tick();
        sat_clr = 1'b0; valid_in = '0;
        tests_run++; if (a_flag !== 4'b0001) begin tests_failed++; $display("[TB] FAIL sat_clr_vs_set: got %b want 0001", a_flag); end
        tick();
        tests_run++; if (a_flag !== 4'b0001) begin tests_failed++; $display("[TB] FAIL sat_after_clr: got %b want 0001", a_flag); end
    endtask

    task automatic test_wrap();
        write_w(0, 0, 16'h7000);
        w_data_in = {16'h0, 16'h0, 16'h0, 16'h7000}; w_valid_in = 4'b0001; w_set_sel = 0;
        tick();
        tests_run++; if (w_z_data !== {48'h0, 16'hE000}) begin tests_failed++; $display("[TB] FAIL wrap_data: got %h want e000 in lane0", w_z_data); end
        tests_run++; if (w_flag !== 4'b0001) begin tests_failed++; $display("[TB] FAIL wrap_flag: got %b want 0001", w_flag); end
        w_valid_in = '0;
        write_w(5, 0, 16'h1234);
        w_data_in = {16'h0, 16'h0, 16'h0, 16'h0100}; w_valid_in = 4'b0001; w_set_sel = 5;
        tick();
        tests_run++; if (w_z_data !== {48'h0, 16'h0100}) begin tests_failed++; $display("[TB] FAIL oob_read_zero: got %h want 0100 in lane0", w_z_data); end
        w_data_in = '0; w_set_sel = 1;
        tick();
        tests_run++; if (w_z_data !== '0) begin tests_failed++; $display("[TB] FAIL oob_write_ignored: got %h want 0", w_z_data); end
        w_data_in = {16'h0, 16'h0, 16'h0, 16'h0010}; w_set_sel = 0;
        tick();
        tests_run++; if (w_z_data !== {48'h0, 16'h7010}) begin tests_failed++; $display("[TB] FAIL oob_set0_intact: got %h want 7010 in lane0", w_z_data); end
        w_valid_in = '0;
    endtask

    task automatic test_collision();
        write_a(2, 0, 16'h0005);
        wr_en = 1'b1; wr_set = 2; wr_lane = 0; wr_data = 16'h0010;
        set_sel = 2; data_in = '0; valid_in = 4'b0001;
        tick();
        wr_en = 1'b0;
        tests_run++; if (a_z_data[15:0] !== 16'h0005) begin tests_failed++; $display("[TB] FAIL collision_old: got %h want 0005", a_z_data[15:0]); end
        tick();
        tests_run++; if (a_z_data[15:0] !== 16'h0010) begin tests_failed++; $display("[TB] FAIL collision_new: got %h want 0010", a_z_data[15:0]); end
        valid_in = '0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            data_in = {$urandom, $urandom}; valid_in = LANES'($urandom); set_sel = SET_W'($urandom);
            wr_en = 1'($urandom); wr_set = SET_W'($urandom); wr_lane = LANE_W'($urandom); wr_data = DATA_W'($urandom);
            sat_clr = ($urandom_range(0, 7) == 0);
            w_data_in = {$urandom, $urandom}; w_valid_in = LANES'($urandom); w_set_sel = W_SET_W'($urandom);
            w_wr_en = 1'($urandom); w_wr_set = W_SET_W'($urandom); w_wr_lane = LANE_W'($urandom); w_wr_data = DATA_W'($urandom);
            w_sat_clr = ($urandom_range(0, 7) == 0);
            tick();
            tests_run++; if (a_z_data !== exp_a_data || a_z_valid !== exp_a_valid) begin
                tests_failed++; $display("[TB] FAIL rand_a_out[%0d]: got %h/%b want %h/%b", n, a_z_data, a_z_valid, exp_a_data, exp_a_valid);
            end
            tests_run++; if (a_flag !== exp_a_flag) begin
                tests_failed++; $display("[TB] FAIL rand_a_flag[%0d]: got %b want %b", n, a_flag, exp_a_flag);
            end
            tests_run++; if (w_z_data !== exp_w_data || w_z_valid !== exp_w_valid) begin
                tests_failed++; $display("[TB] FAIL rand_w_out[%0d]: got %h/%b want %h/%b", n, w_z_data, w_z_valid, exp_w_data, exp_w_valid);
            end
            tests_run++; if (w_flag !== exp_w_flag) begin
                tests_failed++; $display("[TB] FAIL rand_w_flag[%0d]: got %b want %b", n, w_flag, exp_w_flag);
            end
        end
        wr_en = 1'b0; w_wr_en = 1'b0; sat_clr = 1'b0; w_sat_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        data_in = {$urandom, $urandom} | {4{16'h0001}}; valid_in = 4'hF; set_sel = 1;
        w_data_in = {4{16'h0101}}; w_valid_in = 4'hF; w_set_sel = 0;
        tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        tests_run++; if (a_z_data !== '0 || a_z_valid !== '0 || a_flag !== '0) begin
            tests_failed++; $display("[TB] FAIL async_reset_a: got %h/%b/%b want 0", a_z_data, a_z_valid, a_flag);
        end
        tests_run++; if (w_z_data !== '0 || w_z_valid !== '0 || w_flag !== '0) begin
            tests_failed++; $display("[TB] FAIL async_reset_w: got %h/%b/%b want 0", w_z_data, w_z_valid, w_flag);
        end
        model_reset();
        tick();
        rst = 1'b1;
        data_in = {4{16'h0123}}; valid_in = 4'hF; set_sel = 1;
        tick();
        tests_run++; if (a_z_data !== {4{16'h0123}}) begin
            tests_failed++; $display("[TB] FAIL post_reset_bias_zero: got %h want 0123 x4", a_z_data);
        end
        valid_in = '0; w_valid_in = '0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_lane_valid();
        test_saturation();
        test_wrap();
        test_collision();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bias_array.md
Name: bias_array

Overview:
- Parametrised multi-lane successor to the single-lane bias adder. Sits between the systolic array's bottom edge and the activation stage.
- Each lane adds a per-lane, per-set signed fixed-point bias to the incoming column result and registers it with a valid flag.
- Bias values live in an internal register file loaded through a write port; the active set is selected per input beat.
- Overflow behaviour is selectable (saturate or wrap), with sticky per-lane overflow flags.

Parameters:
- LANES, 4, number of parallel columns.
- DATA_W, 16, signed fixed-point width of data and bias (format is transparent; integer add).
- SETS, 4, number of bias sets (e.g. one per layer); SET_W = max(1, clog2(SETS)).
- SATURATE, 1, 1 = clamp to the signed range, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bias_sys_data_in  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W], signed.
- bias_sys_valid_in  in  LANES  per-lane input valid.
- bias_set_sel  in  SET_W  bias set applied to this cycle's inputs.
- bias_wr_en  in  1  bias register write strobe.
- bias_wr_set  in  SET_W  target set for write.
- bias_wr_lane  in  clog2(LANES) (min 1)  target lane for write.
- bias_wr_data  in  DATA_W  signed bias value.
- bias_sat_clr  in  1  clears all sticky overflow flags.
- bias_z_data_out  out  LANES*DATA_W  registered biased results.
- bias_z_valid_out  out  LANES  registered per-lane valid.
- bias_sat_flag  out  LANES  sticky per-lane overflow flag.

Behaviour:
- While rst=0: all outputs are 0 and all bias registers are cleared to 0. Deassertion takes effect synchronously at the next clk edge; the block is idle and in a clean state.
- Latency is 1 cycle; there is no backpressure and no stall.
- Each lane is independent. On an edge with bias_sys_valid_in[i]=1:
  - bias_z_valid_out[i] <= 1.
  - bias_z_data_out lane i <= f(data_i + bias[bias_set_sel][i]).
- With valid[i]=0, lane i output data and valid are both driven to 0 at that edge (no hold).
- Arithmetic: sign-extend both operands to DATA_W+1 and add.
  - Overflow occurs when the sum lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - SATURATE=1: clamp to 0x7FFF / 0x8000 (for DATA_W=16).
  - SATURATE=0: keep the low DATA_W bits.
- bias_sat_flag[i] sets on an edge where lane i is valid and overflows, regardless of SATURATE. It stays set until cleared.
- Sticky-flag clear: bias_sat_clr=1 clears all flags at the edge. If a lane overflows on the same edge as a clear, set wins for that lane.
- Bias write: on an edge with bias_wr_en=1, bias[bias_wr_set][bias_wr_lane] <= bias_wr_data.
- Write/read collision on the same entry in the same cycle: the add uses the old value; the new value is visible from the next cycle.
- Out-of-range indices (bias_set_sel or bias_wr_set >= SETS, bias_wr_lane >= LANES):
  - A write is ignored.
  - A read uses bias value 0.
- Reset mid-stream: in-flight results are discarded, outputs go to 0, and biases must be reloaded.

Decomposition:
- Shared package/header holds:
  - the saturation bounds as DATA_W-derived localparams;
  - a safe-clog2 macro/function (min 1) for SET_W and the lane-index width.
- One natural sub-module: bias_lane. It takes data, bias, valid, clk and rst, and produces a registered, saturated or wrapped result, valid, and an overflow pulse.
- The top instantiates LANES copies with generate, and owns the bias register file and the sticky flags.
- Each lane's adder may reuse fxp_add extended by one bit, or be written inline.

Test Plan (LANES=4, DATA_W=16, SETS=4, SATURATE=1 unless noted):
- Reset and load:
  - Hold rst=0 with nonzero inputs: all outputs 0.
  - Release reset, write set1 biases {0x0100, 0xFF00, 0x0000, 0x0080}, drive data {0x0200 x4}, valid=4'hF, sel=1.
  - Next cycle: outputs {0x0300, 0x0100, 0x0200, 0x0280}, valid=4'hF.
- Per-lane valid:
  - Valid=4'b0101: lanes 1 and 3 output data 0, valid 0.
  - Lanes 0 and 2 produce correct sums one cycle later.
  - Then drop valid to 0: all outputs return to 0 the next cycle.
- Saturation:
  - Set0 lane0 = 0x7000, data 0x7000: output 0x7FFF, flag[0]=1.
  - Lane1 with bias 0x9000 and data 0x9000: output 0x8000.
  - Flags persist after valid drops.
  - Assert bias_sat_clr together with a new overflow on lane0: flag[0] stays 1 and flag[1] clears.
- Wrap mode (SATURATE=0):
  - Bias 0x7000 plus data 0x7000 outputs 0xE000, and flag[0] still sets.
- Write/read collision:
  - Same cycle, write set2 lane0 = 0x0010 while valid with sel=2 and the old value 0x0005, data 0: output 0x0005.
  - The following beat outputs 0x0010.
  - Write with bias_wr_set=5 (>=SETS, use SET_W=3 build): no change.
- Async reset mid-stream:
  - Assert rst=0 between clock edges during continuous valid traffic: outputs go to 0 immediately without a clock edge.
  - Afterwards, biases read 0: data 0x0123 outputs 0x0123.
